// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet batch controller.
//   batch_state_e  : controller FSM states
//   BYTES_PER_ADDR : result bytes packed into one SRAM F word address
//   RESULT_IDX_W   : width of the class-index field
package lenet_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StDrain
    } batch_state_e;

    localparam int unsigned BYTES_PER_ADDR = 4;
    localparam int unsigned RESULT_IDX_W   = 4;

endpackage

// File: rtl/lenet_result_buf.sv
// Result capture buffer: NUM_SET x RESULT_NUM bytes.
//   clk, rst : clock, async active-high reset
//   clear    : synchronous clear of the whole array (wins over writes)
//   wr_en    : per-byte-lane write strobes of the current word address
//   wr_addr  : word address; strobe b targets index wr_addr*4+b
//   wr_data  : one byte per lane, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_lane, rd_idx, rd_data : combinational read port
module lenet_result_buf
    import lenet_pkg::*;
#(
    parameter int unsigned NUM_SET    = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RESULT_NUM = 10,
    parameter int unsigned LANE_W     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [BYTES_PER_ADDR-1:0]     wr_en,
    input  logic [1:0]                    wr_addr,
    input  logic [NUM_SET*DATA_WIDTH-1:0] wr_data,
    input  logic [LANE_W-1:0]             rd_lane,
    input  logic [RESULT_IDX_W-1:0]       rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [NUM_SET-1:0][RESULT_NUM-1:0][DATA_WIDTH-1:0] mem_q;

    // Indices >= RESULT_NUM have no storage, so those strobes simply drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (clear) begin
            mem_q <= '0;
        end else begin
            for (int l = 0; l < NUM_SET; l++) begin
                for (int r = 0; r < RESULT_NUM; r++) begin
                    if (wr_en[r % BYTES_PER_ADDR] && wr_addr == 2'(r / BYTES_PER_ADDR)) begin
                        mem_q[l][r] <= wr_data[l*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_lane) < NUM_SET && int'(rd_idx) < RESULT_NUM) begin
            rd_data = mem_q[rd_lane][rd_idx];
        end
    end

endmodule

// File: rtl/lenet_batch_ctrl.sv
// Batch controller for NUM_SET lockstep LeNet cores.
//   batch_valid/batch_ready/batch_mask : host batch request, lane-valid mask
//   conv_start                          : one-cycle start pulse to all cores
//   core_*                              : lane 0 control, all lanes' SRAM F data
//   res_valid/res_ready/res_data/res_lane/res_idx/res_last : result byte stream
//   busy        : controller not idle
//   timeout_err : sticky, last batch aborted by the watchdog
module lenet_batch_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned NUM_SET     = 2,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned RESULT_NUM  = 10,
    parameter int unsigned TIMEOUT_CYC = 2**20 - 1,
    localparam int unsigned LANE_W     = (NUM_SET > 1) ? $clog2(NUM_SET) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          batch_valid,
    output logic                          batch_ready,
    input  logic [NUM_SET-1:0]            batch_mask,
    output logic                          conv_start,
    input  logic                          core_fc2_done,
    input  logic                          core_write_enable_f,
    input  logic [3:0]                    core_bytemask_f,
    input  logic [1:0]                    core_waddr_f,
    input  logic [NUM_SET*DATA_WIDTH-1:0] core_wdata_f,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [LANE_W-1:0]             res_lane,
    output logic [RESULT_IDX_W-1:0]       res_idx,
    output logic                          res_last,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    batch_state_e state_q, state_d;

    logic [NUM_SET-1:0]      mask_q, mask_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    timeout_q, timeout_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [RESULT_IDX_W-1:0] idx_q, idx_d;

    logic [LANE_W-1:0]       first_lane, last_lane, next_lane;
    logic                    wd_expired, idx_end, lane_end;
    logic                    buf_clear;
    logic [3:0]              buf_wr_en;
    logic [DATA_WIDTH-1:0]   buf_rd_data;

    // Counter reaches TIMEOUT_CYC on this RUN cycle.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign idx_end    = (idx_q == RESULT_IDX_W'(RESULT_NUM - 1));
    assign lane_end   = (lane_q == last_lane);

    // Mask-skip helpers over the latched mask.
    always_comb begin
        first_lane = '0;
        last_lane  = '0;
        next_lane  = '0;
        for (int i = NUM_SET - 1; i >= 0; i--) begin
            if (mask_q[i]) first_lane = LANE_W'(i);
            if (mask_q[i] && i > int'(lane_q)) next_lane = LANE_W'(i);
        end
        for (int i = 0; i < NUM_SET; i++) begin
            if (mask_q[i]) last_lane = LANE_W'(i);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (batch_valid && |batch_mask) state_d = StStart;
            StStart: state_d = StRun;
            StRun: begin
                if (core_fc2_done)   state_d = StDrain;
                else if (wd_expired) state_d = StIdle;
            end
            StDrain: if (res_ready && idx_end && lane_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state: mask, watchdog, sticky error, drain pointer.
    always_comb begin
        mask_d    = mask_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        lane_d    = lane_q;
        idx_d     = idx_q;
        buf_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                // An all-zero mask is still accepted; it just issues nothing.
                if (batch_valid) begin
                    mask_d    = batch_mask;
                    wd_d      = '0;
                    timeout_d = 1'b0;
                    buf_clear = 1'b1;
                end
            end
            StRun: begin
                wd_d = wd_q + 1'b1;
                if (core_fc2_done) begin
                    lane_d = first_lane;
                    idx_d  = '0;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    buf_clear = 1'b1;
                end
            end
            StDrain: begin
                if (res_ready) begin
                    if (!idx_end) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d  = '0;
                        lane_d = lane_end ? '0 : next_lane;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            lane_q    <= '0;
            idx_q     <= '0;
        end else begin
            mask_q    <= mask_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            lane_q    <= lane_d;
            idx_q     <= idx_d;
        end
    end

    // Capture only in RUN; write enable and byte mask are active-low.
    assign buf_wr_en = (state_q == StRun && !core_write_enable_f) ? ~core_bytemask_f : 4'b0000;

    lenet_result_buf #(
        .NUM_SET    (NUM_SET),
        .DATA_WIDTH (DATA_WIDTH),
        .RESULT_NUM (RESULT_NUM),
        .LANE_W     (LANE_W)
    ) u_result_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (buf_clear),
        .wr_en   (buf_wr_en),
        .wr_addr (core_waddr_f),
        .wr_data (core_wdata_f),
        .rd_lane (lane_q),
        .rd_idx  (idx_q),
        .rd_data (buf_rd_data)
    );

    // Outputs come straight from state/pointer flops and the (static) buffer.
    always_comb begin
        batch_ready = (state_q == StIdle);
        conv_start  = (state_q == StStart);
        busy        = (state_q != StIdle);
        res_valid   = (state_q == StDrain);
        res_data    = res_valid ? buf_rd_data : '0;
        res_lane    = res_valid ? lane_q : '0;
        res_idx     = res_valid ? idx_q : '0;
        res_last    = res_valid && idx_end && lane_end;
        timeout_err = timeout_q;
    end

endmodule
